// File: rtl/array_mac_pkg.sv
// Shared width helpers and stage-record control fields for the multi-lane MAC pipeline.
package array_mac_pkg;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int sum_w(input int dw, input int lanes);
    return (lanes > 1) ? (2 * dw + $clog2(lanes)) : (2 * dw);
  endfunction

  // Control half of a stage record; the lane_sum payload width depends on the instance.
  typedef struct packed {
    logic valid;
    logic last;
  } stage_ctl_t;

endpackage

// File: rtl/array_mac_lane.sv
// One unsigned DATAWIDTH x DATAWIDTH multiplier lane of the MAC array.
module array_mac_lane
  import array_mac_pkg::*;
#(
  parameter int DATAWIDTH = 4
) (
  input  logic [DATAWIDTH-1:0]          a_i,
  input  logic [DATAWIDTH-1:0]          b_i,
  output logic [prod_w(DATAWIDTH)-1:0]  p_o
);

  assign p_o = prod_w(DATAWIDTH)'(a_i) * prod_w(DATAWIDTH)'(b_i);

endmodule

// File: rtl/array_mac_pipeline.sv
// Multi-lane dot-product MAC with stall-enabled pipeline and frame accumulator.
// Optional MAC_SATURATE_EN: saturating accumulate with a sticky per-frame o_overflow flag.
module array_mac_pipeline
  import array_mac_pkg::*;
#(
  parameter int DATAWIDTH           = 4,
  parameter int NUM_LANES           = 2,
  parameter int NUM_PIPELINE_STAGES = 1,
  parameter int ACC_WIDTH           = 2 * DATAWIDTH + 8,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_last,
  input  logic [NUM_LANES*DATAWIDTH-1:0] A,
  input  logic [NUM_LANES*DATAWIDTH-1:0] B,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [ACC_WIDTH-1:0]           Z_final
`ifdef MAC_SATURATE_EN
  ,
  output logic                           o_overflow
`endif
);

  localparam int PROD_W = prod_w(DATAWIDTH);
  localparam int SUM_W  = sum_w(DATAWIDTH, NUM_LANES);

  if (ACC_WIDTH < SUM_W || NUM_LANES < 1 || NUM_PIPELINE_STAGES < 1 || INSTANCE_ID < 0) begin : g_bad_cfg
    $error("array_mac_pipeline: illegal parameter set (ACC_WIDTH must cover the lane sum)");
  end

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [SUM_W-1:0] lane_sum;
  } stage_t;

  logic [PROD_W-1:0]    prod_s [NUM_LANES];
  logic [SUM_W-1:0]     lane_sum_s;
  logic                 advance_s;
  stage_t               stage_in_s;
  stage_t               tail_s;
  stage_t               stage_q [NUM_PIPELINE_STAGES];
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] z_q, z_d;
  logic [ACC_WIDTH-1:0] sum_s;
  logic                 vld_q, vld_d;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    array_mac_lane #(.DATAWIDTH(DATAWIDTH)) u_lane (
      .a_i (A[k*DATAWIDTH +: DATAWIDTH]),
      .b_i (B[k*DATAWIDTH +: DATAWIDTH]),
      .p_o (prod_s[k])
    );
  end

  always_comb begin
    lane_sum_s = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_sum_s = lane_sum_s + SUM_W'(prod_s[k]);
    end
  end

  // A full, unconsumed result freezes the whole pipeline.
  assign advance_s = !vld_q || i_ready;
  assign o_ready   = advance_s && !rst;

  always_comb begin
    stage_in_s.ctl.valid = i_valid && o_ready;
    stage_in_s.ctl.last  = i_last;
    stage_in_s.lane_sum  = lane_sum_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPELINE_STAGES; i++) stage_q[i] <= '0;
    end else if (advance_s) begin
      stage_q[0] <= stage_in_s;
      for (int i = 1; i < NUM_PIPELINE_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail_s = stage_q[NUM_PIPELINE_STAGES-1];

`ifdef MAC_SATURATE_EN
  logic [ACC_WIDTH:0] wide_s;
  logic               carry_s;
  logic               ovf_q, ovf_d;
  logic               ovf_out_q, ovf_out_d;

  assign wide_s  = {1'b0, acc_q} + (ACC_WIDTH+1)'(tail_s.lane_sum);
  assign carry_s = wide_s[ACC_WIDTH];
  assign sum_s   = carry_s ? {ACC_WIDTH{1'b1}} : wide_s[ACC_WIDTH-1:0];
  assign o_overflow = ovf_out_q;
`else
  assign sum_s = acc_q + ACC_WIDTH'(tail_s.lane_sum);
`endif

  always_comb begin
    acc_d = acc_q;
    z_d   = z_q;
    vld_d = vld_q;
`ifdef MAC_SATURATE_EN
    ovf_d     = ovf_q;
    ovf_out_d = ovf_out_q;
`endif
    if (advance_s) begin
      vld_d = 1'b0;
      if (tail_s.ctl.valid && tail_s.ctl.last) begin
        z_d   = sum_s;
        vld_d = 1'b1;
        acc_d = '0;
`ifdef MAC_SATURATE_EN
        ovf_out_d = ovf_q || carry_s;
        ovf_d     = 1'b0;
`endif
      end else if (tail_s.ctl.valid) begin
        acc_d = sum_s;
`ifdef MAC_SATURATE_EN
        ovf_d = ovf_q || carry_s;
`endif
      end else begin
        acc_d = acc_q;
      end
    end else begin
      vld_d = vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      z_q   <= '0;
      vld_q <= 1'b0;
`ifdef MAC_SATURATE_EN
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      z_q   <= z_d;
      vld_q <= vld_d;
`ifdef MAC_SATURATE_EN
      ovf_q     <= ovf_d;
      ovf_out_q <= ovf_out_d;
`endif
    end
  end

  assign o_valid = vld_q;
  assign Z_final = z_q;

endmodule

// File: tb/tb_array_mac_pipeline.sv
// Directed bench for array_mac_pipeline: a 16-bit-accumulator instance and a 9-bit one for wrap/saturate.
module tb_array_mac_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_last, i_ready, o_ready, o_valid;
  logic [7:0]  A, B;
  logic [15:0] Z_final;
  logic        v2, l2, r2, o_ready2, o_valid2;
  logic [7:0]  A2, B2;
  logic [8:0]  Z2;
  int          checks = 0;
  int          errors = 0;
`ifdef MAC_SATURATE_EN
  logic        ovf1, ovf2;
`endif

  always #5 clk = ~clk;

  array_mac_pipeline #(.DATAWIDTH(4), .NUM_LANES(2), .NUM_PIPELINE_STAGES(1), .ACC_WIDTH(16), .INSTANCE_ID(0)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_last(i_last),
    .A(A), .B(B), .o_valid(o_valid), .i_ready(i_ready), .Z_final(Z_final)
`ifdef MAC_SATURATE_EN
    , .o_overflow(ovf1)
`endif
  );

  array_mac_pipeline #(.DATAWIDTH(4), .NUM_LANES(2), .NUM_PIPELINE_STAGES(1), .ACC_WIDTH(9), .INSTANCE_ID(1)) dut9 (
    .clk(clk), .rst(rst), .i_valid(v2), .o_ready(o_ready2), .i_last(l2),
    .A(A2), .B(B2), .o_valid(o_valid2), .i_ready(r2), .Z_final(Z2)
`ifdef MAC_SATURATE_EN
    , .o_overflow(ovf2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1; A = 8'd0; B = 8'd0;
    v2 = 1'b0; l2 = 1'b0; r2 = 1'b1; A2 = 8'd0; B2 = 8'd0;
    tick();
    tick();
    chk("rst_o_ready", 32'(o_ready), 32'd0);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_z", 32'(Z_final), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_o_ready", 32'(o_ready), 32'd1);

    // single beat 3*2 + 5*4 = 26
    i_valid = 1'b1; i_last = 1'b1; A = {4'd5, 4'd3}; B = {4'd4, 4'd2};
    tick();
    i_valid = 1'b0; i_last = 1'b0;
    chk("t1_lat1_valid", 32'(o_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_z", 32'(Z_final), 32'd26);
    tick();
    chk("t1_one_cycle", 32'(o_valid), 32'd0);

    // three beats of 450 -> 1350
    i_valid = 1'b1; A = {4'd15, 4'd15}; B = {4'd15, 4'd15};
    tick();
    chk("t2_b1_valid", 32'(o_valid), 32'd0);
    tick();
    chk("t2_b2_valid", 32'(o_valid), 32'd0);
    i_last = 1'b1;
    tick();
    chk("t2_b3_valid", 32'(o_valid), 32'd0);
    i_valid = 1'b0; i_last = 1'b0;
    tick();
    chk("t2_valid", 32'(o_valid), 32'd1);
    chk("t2_z", 32'(Z_final), 32'd1350);
    tick();
    chk("t2_retired", 32'(o_valid), 32'd0);

    // backpressure: result 1*3 + 2*4 = 11 held, next beat (2) offered while stalled
    i_ready = 1'b0;
    i_valid = 1'b1; i_last = 1'b1; A = {4'd2, 4'd1}; B = {4'd4, 4'd3};
    tick();
    i_valid = 1'b0;
    tick();
    chk("t3_valid", 32'(o_valid), 32'd1);
    chk("t3_z", 32'(Z_final), 32'd11);
    i_valid = 1'b1; i_last = 1'b1; A = {4'd1, 4'd1}; B = {4'd1, 4'd1};
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_ready", 32'(o_ready), 32'd0);
      tick();
      chk("t3_hold_valid", 32'(o_valid), 32'd1);
      chk("t3_hold_z", 32'(Z_final), 32'd11);
    end
    i_ready = 1'b1;
    #1;
    chk("t3_release_ready", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0; i_last = 1'b0;
    chk("t3_retired", 32'(o_valid), 32'd0);
    tick();
    chk("t3_next_valid", 32'(o_valid), 32'd1);
    chk("t3_next_z", 32'(Z_final), 32'd2);
    tick();
    chk("t3_no_dup", 32'(o_valid), 32'd0);

    // ten single-beat frames back-to-back, result 2k
    for (int i = 0; i < 12; i++) begin
      logic [3:0] kk;
      kk = 4'(i + 1);
      if (i < 10) begin
        i_valid = 1'b1; i_last = 1'b1; A = {kk, 4'd1}; B = {4'd1, kk};
      end else begin
        i_valid = 1'b0; i_last = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 10) begin
        chk("t4_valid", 32'(o_valid), 32'd1);
        chk("t4_z", 32'(Z_final), 32'(2 * i));
      end else if (i == 11) begin
        chk("t4_end", 32'(o_valid), 32'd0);
      end
    end

    // reset mid-frame discards partial sum
    i_valid = 1'b1; i_last = 1'b0; A = {4'd15, 4'd15}; B = {4'd15, 4'd15};
    tick();
    tick();
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", 32'(o_ready), 32'd0);
    tick();
    rst = 1'b0;
    i_valid = 1'b1; i_last = 1'b1; A = {4'd1, 4'd1}; B = {4'd1, 4'd1};
    tick();
    i_valid = 1'b0; i_last = 1'b0;
    tick();
    chk("t5_valid", 32'(o_valid), 32'd1);
    chk("t5_z", 32'(Z_final), 32'd2);

    // narrow accumulator: 450 + 450 into 9 bits
    v2 = 1'b1; l2 = 1'b0; A2 = {4'd15, 4'd15}; B2 = {4'd15, 4'd15};
    tick();
    l2 = 1'b1;
    tick();
    v2 = 1'b0; l2 = 1'b0;
    tick();
    chk("t6_valid", 32'(o_valid2), 32'd1);
`ifdef MAC_SATURATE_EN
    chk("t6_z_sat", 32'(Z2), 32'd511);
    chk("t6_ovf", 32'(ovf2), 32'd1);
`else
    chk("t6_z_wrap", 32'(Z2), 32'd388);
`endif
    v2 = 1'b1; l2 = 1'b1; A2 = {4'd5, 4'd3}; B2 = {4'd4, 4'd2};
    tick();
    v2 = 1'b0; l2 = 1'b0;
    tick();
    chk("t6_next_valid", 32'(o_valid2), 32'd1);
    chk("t6_next_z", 32'(Z2), 32'd26);
`ifdef MAC_SATURATE_EN
    chk("t6_next_ovf", 32'(ovf2), 32'd0);
    chk("t6_wide_ovf", 32'(ovf1), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
